// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder_4bit.sv
// 4-bit ripple adder slice: {Cout,Sum} = A + B + Cin.
module fulladder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] total;

    assign total = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
    assign Sum   = total[3:0];
    assign Cout  = total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds a + b + cin one nibble per cycle through a single 4-bit slice, LS nibble first.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
import nibble_adder_pkg::*;

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               capture;
    logic [NIBBLE_W-1:0] a_nib, b_nib, slice_sum;
    logic               slice_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    fulladder_4bit u_slice (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry_q),
        .Sum  (slice_sum),
        .Cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        capture = 1'b0;
        a_nib   = '0;
        b_nib   = '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    carry_d = cin;
                    state_d = CALC;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            CALC: begin
                for (int i = 0; i < NIB; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                // Index holds on the last nibble so it never wraps mid-operation.
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Operand copies are pure data; they are only read while in CALC.
    always_ff @(posedge clk) begin
        if (capture) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases, mid-op reset and random traffic.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; called at posedge+1 with the DUT in IDLE.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input int hold, input bit noisy);
        logic [WIDTH:0] ref_full;
        bit             ref_ovf;
        int             lat;
        ref_full = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
        ref_ovf  = (ta[WIDTH-1] == tb[WIDTH-1]) && (ref_full[WIDTH-1] != ta[WIDTH-1]);
        check("ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            check("ready_low_in_flight", {31'b0, in_ready}, 32'd0);
            if (noisy) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                cin = 1'($urandom);
                in_valid = 1'($urandom);
                out_ready = 1'($urandom);
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("latency", lat, NIB);
        check("result", {15'b0, cout, sum}, {15'b0, ref_full});
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("ovf", {31'b0, ovf}, {31'b0, ref_ovf});
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            a = WIDTH'($urandom);
            step();
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_result", {15'b0, cout, sum}, {15'b0, ref_full});
            check("hold_ready_low", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("back_to_idle_ready", {31'b0, in_ready}, 32'd1);
        check("back_to_idle_valid", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // First accept right after reset release, carry propagates through every nibble
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        // Carry-in plus backpressure for three cycles
        run_op(16'h1234, 16'h4321, 1'b1, 3, 1'b1);

        // Reset during the second CALC cycle
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_sum", {16'b0, sum}, 32'd0);
        check("midrst_cout", {31'b0, cout}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        run_op(16'h7FFF, 16'h0001, 1'b0, 1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, is the operand/result width and SHALL be a multiple of 4 and at least 4; NIB = WIDTH/4.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port in_valid  input  1  operand set A/B/cin is valid.
REQ-005 Port in_ready  output  1  block can accept an operand set.
REQ-006 Port a  input  WIDTH  operand A (unsigned).
REQ-007 Port b  input  WIDTH  operand B (unsigned).
REQ-008 Port cin  input  1  carry-in.
REQ-009 Port out_valid  output  1  result valid.
REQ-010 Port out_ready  input  1  consumer accepts the result.
REQ-011 Port sum  output  WIDTH  registered result.
REQ-012 Port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL add a + b + cin one nibble per cycle, least-significant nibble first, using one 4-bit adder slice.
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 IDLE: in_ready=1; when in_valid=1, capture a, b and cin, set nibble index to 0 and the carry register to cin, then go to CALC.
REQ-016 CALC: each cycle, write the slice Sum into sum nibble[index], load the carry register from the slice Cout, and increment the index; after nibble NIB-1, go to DONE.
REQ-017 DONE: out_valid=1; sum and cout SHALL be held stable until out_ready=1, then return to IDLE.
REQ-018 Latency: out_valid SHALL first be high NIB rising edges after the accepting edge (4 for WIDTH=16); throughput is one operation per NIB+2 cycles minimum.
REQ-019 in_ready SHALL be 0 in CALC and DONE; in_valid in those states SHALL be ignored, and a/b/cin changes SHALL not affect the result in flight.
REQ-020 out_valid SHALL be 0 outside DONE; out_ready outside DONE SHALL be ignored.
REQ-021 {cout,sum} SHALL equal the WIDTH+1-bit value a+b+cin; the carry wraps at bit WIDTH and no other width extension applies.
REQ-022 The index counter SHALL be ceil(log2(NIB)) bits wide (minimum 1) and SHALL not wrap within an operation.

Reset
REQ-023 While rst_n=0, state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, index=0 and carry=0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL discard the operation with no partial result made visible.
REQ-025 The first accept after reset SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro NIBBLE_SERIAL_ADDER_OVF_EN defined: add port ovf  output  1, the signed overflow of the final result, = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), registered and valid with out_valid, 0 in reset.
REQ-027 Macro NIBBLE_SERIAL_ADDER_OVF_EN undefined: no ovf port and no associated logic.

Structure
REQ-028 Package nibble_adder_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and constant NIBBLE_W=4.
REQ-029 The 4-bit slice SHALL be an instance of the existing fulladder_4bit sub-module (A, B, Cin, Sum, Cout); no other sub-module.

Verification
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> 4 edges after accept: out_valid=1, sum=0x0000, cout=1.
REQ-031 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready=0 from accept until return to IDLE.
REQ-032 Hold out_ready=0 for 3 cycles in DONE -> sum/cout/out_valid stable, in_ready=0, and in_valid pulses ignored; out_ready=1 -> next cycle IDLE, in_ready=1.
REQ-033 Assert rst_n=0 during the second CALC cycle -> out_valid, sum and cout read 0 immediately; after release, 0x0001+0x0001 yields 0x0002.
REQ-034 With the macro defined: 0x7FFF+0x0001 -> ovf=1, sum=0x8000, cout=0; 0xFFFF+0x0001 -> ovf=0.
REQ-035 200 random a/b/cin operations with random out_ready backpressure -> every {cout,sum} equals the a+b+cin reference; report the pass/fail totals.
